// File: rtl/calc_seq_display.sv
// calc_seq_display: sequential W-bit calculator (clr/add/sub/mul/restoring div) driving a
// scanned active-low 7-segment bank. Define DECIMAL_EN to show the result as BCD digits.
module calc_seq_display #(
    parameter int W        = 4,
    parameter int NDIG     = 6,
    parameter int SCAN_DIV = 5000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [2:0]      k,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [6:0]      light,
    output logic [NDIG-1:0] en,
    output logic            flagLed,
    output logic            errLed
);
    localparam int MW = 2 * W;
`ifdef DECIMAL_EN
    localparam int NBCD = (2 * W + 2) / 3 + 1;
    localparam int RW   = 4 * NBCD;
`else
    localparam int RW   = MW;
`endif
    localparam int PADW = 4 * NDIG + RW;
    localparam int SCW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IXW  = $clog2(NDIG);
    localparam int CW   = $clog2(MW + 1);

`ifdef DECIMAL_EN
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_DIV, S_CONV, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_EXEC, S_DIV, S_DONE} state_t;
`endif

    state_t          state_q;
    logic [W-1:0]    a_q, b_q, rem_q, quo_q, a_disp_q;
    logic [2:0]      k_q;
    logic [MW-1:0]   wmag_q;
    logic            wflag_q, werr_q;
    logic [CW-1:0]   cnt_q;
    logic [RW-1:0]   res_q;
    logic            busy_q, done_q, flag_q, err_q;
    logic [SCW-1:0]  scan_q;
    logic [IXW-1:0]  idx_q;

    // Operands widened to 2W+1 signed so sub can go negative and mul never overflows.
    logic signed [MW:0] ea, eb, alu_s;
    logic [MW-1:0]      alu_mag_d;
    logic               alu_neg_d, alu_err_d, is_div_d;

    assign ea = $signed({{(W + 1){1'b0}}, a_q});
    assign eb = $signed({{(W + 1){1'b0}}, b_q});

    always_comb begin
        alu_s     = '0;
        alu_err_d = 1'b0;
        is_div_d  = 1'b0;
        case (k_q)
            3'b100:  alu_s = '0;
            3'b101:  alu_s = ea + eb;
            3'b110:  alu_s = ea - eb;
            3'b111:  alu_s = ea * eb;
            3'b011: begin
                is_div_d  = (b_q != '0);
                alu_err_d = (b_q == '0);
            end
            default: alu_err_d = 1'b1;
        endcase
        alu_neg_d = alu_s[MW];
        alu_mag_d = alu_neg_d ? MW'(-alu_s) : alu_s[MW-1:0];
    end

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    logic [W:0]   shift_d;
    logic [W-1:0] rem_d, quo_d;

    always_comb begin
        shift_d = {rem_q, quo_q[W-1]};
        if (shift_d >= {1'b0, b_q}) begin
            rem_d = W'(shift_d - {1'b0, b_q});
            quo_d = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_d = shift_d[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
        end
    end

`ifdef DECIMAL_EN
    logic [RW+MW-1:0] dd_q, dd_adj;

    assign dd_adj[MW-1:0] = dd_q[MW-1:0];
    for (genvar gi = 0; gi < NBCD; gi++) begin : g_dd
        logic [3:0] dig;
        assign dig = dd_q[MW + 4 * gi +: 4];
        assign dd_adj[MW + 4 * gi +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
            res_q    <= '0;
            a_disp_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            wmag_q   <= '0;
            wflag_q  <= 1'b0;
            werr_q   <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
`ifdef DECIMAL_EN
            dd_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        k_q     <= k;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wmag_q  <= alu_mag_d;
                    wflag_q <= alu_neg_d;
                    werr_q  <= alu_err_d;
                    rem_q   <= '0;
                    quo_q   <= a_q;
                    cnt_q   <= '0;
`ifdef DECIMAL_EN
                    dd_q    <= {{RW{1'b0}}, alu_mag_d};
                    if (is_div_d)       state_q <= S_DIV;
                    else if (alu_err_d) state_q <= S_DONE;
                    else                state_q <= S_CONV;
`else
                    state_q <= is_div_d ? S_DIV : S_DONE;
`endif
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        wmag_q <= MW'(quo_d);
`ifdef DECIMAL_EN
                        dd_q    <= {{RW{1'b0}}, MW'(quo_d)};
                        cnt_q   <= '0;
                        state_q <= S_CONV;
`else
                        state_q <= S_DONE;
`endif
                    end
                end
`ifdef DECIMAL_EN
                S_CONV: begin
                    dd_q  <= dd_adj << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(MW - 1)) state_q <= S_DONE;
                end
`endif
                S_DONE: begin
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    flag_q   <= wflag_q;
                    err_q    <= werr_q;
                    a_disp_q <= a_q;
`ifdef DECIMAL_EN
                    res_q    <= dd_q[RW+MW-1:MW];
`else
                    res_q    <= wmag_q;
`endif
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == SCW'(SCAN_DIV - 1)) begin
            scan_q <= '0;
            idx_q  <= (idx_q == IXW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            scan_q <= scan_q + 1'b1;
        end
    end

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'b0000001;
            4'h1: seg_of = 7'b1001111;
            4'h2: seg_of = 7'b0010010;
            4'h3: seg_of = 7'b0000110;
            4'h4: seg_of = 7'b1001100;
            4'h5: seg_of = 7'b0100100;
            4'h6: seg_of = 7'b0100000;
            4'h7: seg_of = 7'b0001111;
            4'h8: seg_of = 7'b0000000;
            4'h9: seg_of = 7'b0000100;
            4'hA: seg_of = 7'b0001000;
            4'hB: seg_of = 7'b1100000;
            4'hC: seg_of = 7'b0110001;
            4'hD: seg_of = 7'b1000010;
            4'hE: seg_of = 7'b0110000;
            default: seg_of = 7'b0111000;
        endcase
    endfunction

    // Zero padding makes unused high result positions read as '0'.
    logic [PADW-1:0] res_pad;
    logic [3:0]      a_nib;
    logic [6:0]      light_d;

    assign res_pad = PADW'(res_q);
    assign a_nib   = 4'(a_disp_q);

    always_comb begin
        light_d = 7'b1111111;
        if (idx_q == IXW'(NDIG - 1))      light_d = seg_of(a_nib);
        else if (idx_q == IXW'(NDIG - 2)) light_d = flag_q ? 7'b1111110 : 7'b1111111;
        else                              light_d = seg_of(res_pad[{idx_q, 2'b00} +: 4]);
    end

    assign light   = light_d;
    assign en      = ~(NDIG'(1) << idx_q);
    assign busy    = busy_q;
    assign done    = done_q;
    assign flagLed = flag_q;
    assign errLed  = err_q;
endmodule

// File: tb/tb_calc_seq_display.sv
// Directed self-checking bench for calc_seq_display (W=4, NDIG=6, SCAN_DIV=4).
module tb_calc_seq_display;
    localparam int W = 4;
    localparam int NDIG = 6;
`ifdef DECIMAL_EN
    localparam int CONV_LAT = 2 * W;
`else
    localparam int CONV_LAT = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    a = '0, b = '0;
    logic [2:0]      k = '0;
    logic            start = 1'b0;
    logic            busy, done, flagLed, errLed;
    logic [6:0]      light;
    logic [NDIG-1:0] en;

    int checks = 0;
    int errors = 0;

    logic [6:0] gly [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                             7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                             7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                             7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    calc_seq_display #(.W(W), .NDIG(NDIG), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .k(k), .start(start),
        .busy(busy), .done(done), .light(light), .en(en),
        .flagLed(flagLed), .errLed(errLed)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_dig(input int v, input int p);
`ifdef DECIMAL_EN
        int d = 1;
        for (int i = 0; i < p; i++) d *= 10;
        return (v / d) % 10;
`else
        return (v >> (4 * p)) & 15;
`endif
    endfunction

    // Waits (bounded) for slot p to be enabled, then returns its segments.
    task automatic read_slot(input int p, output int seg);
        logic [NDIG-1:0] want;
        want = ~(NDIG'(1) << p);
        seg = -1;
        for (int i = 0; i < 40; i++) begin
            if (en === want) begin
                seg = int'(light);
                break;
            end
            tick();
        end
    endtask

    task automatic chk_result(input string tag, input int v, input int av, input bit neg);
        int seg;
        for (int p = 0; p < NDIG - 2; p++) begin
            read_slot(p, seg);
            chk($sformatf("%s_dig%0d", tag, p), seg, int'(gly[exp_dig(v, p)]));
        end
        read_slot(NDIG - 2, seg);
        chk({tag, "_sign"}, seg, neg ? 7'b1111110 : 7'b1111111);
        read_slot(NDIG - 1, seg);
        chk({tag, "_opa"}, seg, int'(gly[av]));
    endtask

    // Pulses start for one cycle and counts cycles from the accepting edge to done.
    task automatic run_op(input int av, input int bv, input int kv, output int lat);
        a = W'(av); b = W'(bv); k = 3'(kv); start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    int lat, seg, ndone;
    logic [NDIG-1:0] exp_en;

    initial begin
        // Reset
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flag", flagLed, 0);
        chk("rst_err", errLed, 0);
        chk("rst_en", en, 6'b111110);
        chk("rst_light", light, 7'b0000001);
        chk_result("rst", 0, 0, 1'b0);
        $display("reset: busy=%0d done=%0d en=%b", busy, done, en);

        // 9 + 7 = 16
        run_op(9, 7, 3'b101, lat);
        chk("add_lat", lat, 2 + CONV_LAT);
        chk("add_flag", flagLed, 0);
        chk("add_busy", busy, 0);
        tick();
        chk("add_done_pulse", done, 0);
        chk_result("add", 16, 9, 1'b0);
        $display("add 9+7: lat=%0d flag=%0d", lat, flagLed);

        // 3 - 8 -> -5
        run_op(3, 8, 3'b110, lat);
        chk("sub_lat", lat, 2 + CONV_LAT);
        chk("sub_flag", flagLed, 1);
        chk_result("sub", 5, 3, 1'b1);
        $display("sub 3-8: lat=%0d flag=%0d", lat, flagLed);

        // 15 * 15 = 225
        run_op(15, 15, 3'b111, lat);
        chk("mul_lat", lat, 2 + CONV_LAT);
        chk("mul_flag", flagLed, 0);
        chk_result("mul", 225, 15, 1'b0);
        $display("mul 15*15: lat=%0d", lat);

        // 13 / 4 = 3, with a start pulse during the divide that must be ignored
        a = 4'd13; b = 4'd4; k = 3'b011; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (lat == 2) begin
                a = 4'd1; b = 4'd1; k = 3'b101; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        chk("div_lat", lat, W + 2 + CONV_LAT);
        chk("div_err", errLed, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("div_no_queue", ndone, 0);
        chk_result("div", 3, 13, 1'b0);
        $display("div 13/4: lat=%0d", lat);

        // 5 / 0 -> error, result 0
        run_op(5, 0, 3'b011, lat);
        chk("dz_lat", lat, 2);
        chk("dz_err", errLed, 1);
        chk_result("dz", 0, 5, 1'b0);
        $display("div 5/0: err=%0d", errLed);

        // 1 + 1 clears the error
        run_op(1, 1, 3'b101, lat);
        chk("clr_err_err", errLed, 0);
        chk_result("p11", 2, 1, 1'b0);
        $display("add 1+1: err=%0d", errLed);

        // illegal k, then clr
        run_op(6, 2, 3'b001, lat);
        chk("ill_err", errLed, 1);
        chk_result("ill", 0, 6, 1'b0);
        $display("illegal k: err=%0d", errLed);
        run_op(3, 8, 3'b110, lat);
        run_op(7, 2, 3'b100, lat);
        chk("clr_lat", lat, 2 + CONV_LAT);
        chk("clr_err", errLed, 0);
        chk("clr_flag", flagLed, 0);
        chk_result("clr", 0, 7, 1'b0);
        $display("clr: err=%0d flag=%0d", errLed, flagLed);

        // Scan: align on the edge where slot 0 becomes active, then step slot by slot
        seg = 0;
        for (int i = 0; i < 40; i++) begin
            exp_en = en;
            tick();
            if (en === 6'b111110 && exp_en !== 6'b111110) begin
                seg = 1;
                break;
            end
        end
        chk("scan_align", seg, 1);
        for (int s = 0; s < NDIG; s++) begin
            exp_en = ~(NDIG'(1) << s);
            repeat (3) tick();
            chk($sformatf("scan_hold%0d", s), en, exp_en);
            tick();
            exp_en = ~(NDIG'(1) << ((s + 1) % NDIG));
            chk($sformatf("scan_next%0d", s), en, exp_en);
        end
        $display("scan: en=%b", en);

        // Reset during divide aborts without done
        a = 4'd13; b = 4'd4; k = 3'b011; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("rstdiv_no_done", ndone, 0);
        chk("rstdiv_busy", busy, 0);
        chk_result("rstdiv", 0, 0, 1'b0);
        $display("reset mid-div: dones=%0d busy=%0d", ndone, busy);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
